spi_frame_arbiter: RTL and testbench

Frame-level controller that shares one byte-level SPI master (`wr_req`/`wr_ack` handshake, `cs_ctrl`, `CPOL`/`CPHA`, `clk_div`) between two requesters. It grants one requester at a time with round-robin fairness and drives chip select with programmable setup, hold and recovery times. It issues 1–16 byte transfers back-to-back, returns each received byte, and signals frame completion. It sits between the register/command logic and the SPI master instance in the peripheral tier.

---
 rtl/spi_frame_arbiter_if.sv | 31 +++
 rtl/spi_frame_arbiter.sv | 127 ++++++++++++
 tb/tb_spi_frame_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_arbiter_if.sv
// spi_frame_arbiter_if: requester-side and SPI-master-side signals of the frame arbiter.
interface spi_frame_arbiter_if;
    logic        req0, req1;
    logic [3:0]  len0, len1;
    logic [1:0]  mode0, mode1;
    logic [15:0] div0, div1;
    logic [7:0]  txd0, txd1;
    logic        grant0, grant1;
    logic        tx_take0, tx_take1;
    logic [7:0]  rxd;
    logic        rx_vld0, rx_vld1;
    logic        done0, done1;
    logic        spi_cs_ctrl, spi_cpol, spi_cpha;
    logic [15:0] spi_clk_div;
    logic        spi_wr_req, spi_wr_ack;
    logic [7:0]  spi_data_tx, spi_data_rx;

    modport slave (
        input  req0, req1, len0, len1, mode0, mode1, div0, div1, txd0, txd1,
        input  spi_wr_ack, spi_data_rx,
        output grant0, grant1, tx_take0, tx_take1, rxd, rx_vld0, rx_vld1, done0, done1,
        output spi_cs_ctrl, spi_cpol, spi_cpha, spi_clk_div, spi_wr_req, spi_data_tx
    );

    modport master (
        output req0, req1, len0, len1, mode0, mode1, div0, div1, txd0, txd1,
        output spi_wr_ack, spi_data_rx,
        input  grant0, grant1, tx_take0, tx_take1, rxd, rx_vld0, rx_vld1, done0, done1,
        input  spi_cs_ctrl, spi_cpol, spi_cpha, spi_clk_div, spi_wr_req, spi_data_tx
    );
endinterface

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: round-robin frame controller sharing one byte-level SPI master
// between two requesters, with programmable CS setup, hold and recovery times.
module spi_frame_arbiter #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    spi_frame_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT_ACK, BYTE_GAP, HOLD, DONE, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [7:0]  rxd_q, rxd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  mode_q, mode_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        cs_q, cs_d;
    logic        vld_q, vld_d;
    logic        win, busy;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rxd_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            mode_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cs_q    <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rxd_q   <= rxd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            vld_q   <= vld_d;
        end
    end

    // On a tie the requester that was not served last wins
    assign win = (bus.req0 && bus.req1) ? !last_q : bus.req1;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rxd_d   = rxd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        owner_d = owner_q;
        last_d  = last_q;
        cs_d    = cs_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = SETUP;
                    owner_d = win;
                    cnt_d   = win ? bus.len1 : bus.len0;
                    mode_d  = win ? bus.mode1 : bus.mode0;
                    div_d   = win ? bus.div1 : bus.div0;
                    tmr_d   = 8'(CS_SETUP - 1);
                    cs_d    = 1'b0;
                end
            end
            SETUP: begin
                state_d = (tmr_q == 8'd0) ? ISSUE : SETUP;
                tmr_d   = tmr_q - 8'd1;
            end
            ISSUE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.spi_wr_ack) begin
                    rxd_d   = bus.spi_data_rx;
                    vld_d   = 1'b1;
                    state_d = (cnt_q == 4'd0) ? HOLD : BYTE_GAP;
                    cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                    tmr_d   = 8'(CS_HOLD - 1);
                end
            end
            BYTE_GAP: state_d = ISSUE;
            HOLD: begin
                state_d = (tmr_q == 8'd0) ? DONE : HOLD;
                cs_d    = (tmr_q == 8'd0);
                tmr_d   = tmr_q - 8'd1;
            end
            DONE: begin
                state_d = RECOVER;
                last_d  = owner_q;
                tmr_d   = 8'(CS_GAP - 1);
            end
            RECOVER: begin
                state_d = (tmr_q == 8'd0) ? IDLE : RECOVER;
                tmr_d   = tmr_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy            = (state_q != IDLE) && (state_q != RECOVER);
    assign bus.grant0      = busy && !owner_q;
    assign bus.grant1      = busy && owner_q;
    assign bus.tx_take0    = (state_q == ISSUE) && !owner_q;
    assign bus.tx_take1    = (state_q == ISSUE) && owner_q;
    assign bus.rx_vld0     = vld_q && !owner_q;
    assign bus.rx_vld1     = vld_q && owner_q;
    assign bus.done0       = (state_q == DONE) && !owner_q;
    assign bus.done1       = (state_q == DONE) && owner_q;
    assign bus.rxd         = rxd_q;
    assign bus.spi_cs_ctrl = cs_q;
    assign bus.spi_cpol    = mode_q[1];
    assign bus.spi_cpha    = mode_q[0];
    assign bus.spi_clk_div = div_q;
    assign bus.spi_wr_req  = (state_q == ISSUE);
    assign bus.spi_data_tx = owner_q ? bus.txd1 : bus.txd0;
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb_spi_frame_arbiter: directed bench; the SPI master is modelled by the stimulus
// sequence answering each wr_req with a (optionally scrambled) loopback ack.
module tb_spi_frame_arbiter;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_req = 0, n_vld0 = 0, n_vld1 = 0, n_done0 = 0, n_g1 = 0, n_cs_bad = 0;
    logic [7:0] rx_xor = 8'h00;

    spi_frame_arbiter_if bus ();

    spi_frame_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_req    += int'(bus.spi_wr_req);
        n_vld0   += int'(bus.rx_vld0);
        n_vld1   += int'(bus.rx_vld1);
        n_done0  += int'(bus.done0);
        n_g1     += int'(bus.grant1);
        n_cs_bad += int'((bus.grant0 || bus.grant1) && bus.spi_cs_ctrl && !(bus.done0 || bus.done1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sel 0: wr_req, 1: done, 2: any grant; n = cycles waited
    task automatic wait_for(input int sel, output int n);
        n = 0;
        while (!(sel == 0 ? bus.spi_wr_req : sel == 1 ? (bus.done0 || bus.done1) :
                 (bus.grant0 || bus.grant1)) && n < 100) begin
            step();
            n++;
        end
    endtask

    // Called in the ISSUE cycle; returns in the cycle after the ack
    task automatic xfer(input int lat);
        logic [7:0] tx;
        tx = bus.spi_data_tx;
        step();
        repeat (lat) step();
        bus.spi_wr_ack  = 1'b1;
        bus.spi_data_rx = tx ^ rx_xor;
        step();
        bus.spi_wr_ack  = 1'b0;
    endtask

    // Called in the first grant cycle; returns in the done cycle
    task automatic frame(input int nb, input logic own, input logic [7:0] start);
        int n;
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            b = start + 8'(i);
            bus.txd0 = b;
            bus.txd1 = b;
            wait_for(0, n);
            chk("req_spacing", n, (i == 0) ? CS_SETUP : 1);
            chk("data_tx", bus.spi_data_tx, b);
            chk("tx_take", {bus.tx_take1, bus.tx_take0}, own ? 2 : 1);
            xfer(i % 3);
            chk("rxd", bus.rxd, b ^ rx_xor);
            chk("rx_vld", {bus.rx_vld1, bus.rx_vld0}, own ? 2 : 1);
        end
        wait_for(1, n);
        chk("done_latency", n, CS_HOLD);
        chk("done_owner", {bus.done1, bus.done0}, own ? 2 : 1);
        chk("cs_high_at_done", bus.spi_cs_ctrl, 1);
    endtask

    initial begin
        int n, r0, v0, d0;
        bus.req0 = 0; bus.req1 = 0; bus.len0 = 0; bus.len1 = 0;
        bus.mode0 = 0; bus.mode1 = 0; bus.div0 = 0; bus.div1 = 0;
        bus.txd0 = 0; bus.txd1 = 0; bus.spi_wr_ack = 0; bus.spi_data_rx = 0;
        step();
        step();
        chk("rst_cs", bus.spi_cs_ctrl, 1);
        chk("rst_mode", {bus.spi_cpol, bus.spi_cpha}, 0);
        chk("rst_div", bus.spi_clk_div, 0);
        chk("rst_rxd", bus.rxd, 0);
        chk("rst_outs", {bus.grant0, bus.grant1, bus.tx_take0, bus.tx_take1, bus.rx_vld0,
                         bus.rx_vld1, bus.done0, bus.done1, bus.spi_wr_req}, 0);
        rst = 0;
        step();

        // single byte with loopback and a spurious ack during setup
        bus.txd0 = 8'hA5; bus.len0 = 0; bus.div0 = 16'd5; bus.req0 = 1;
        step();
        chk("sb_grant", {bus.grant1, bus.grant0}, 1);
        chk("sb_cs_low", bus.spi_cs_ctrl, 0);
        bus.spi_wr_ack = 1; bus.spi_data_rx = 8'hEE;
        step();
        bus.spi_wr_ack = 0;
        chk("spurious_vld", bus.rx_vld0, 0);
        chk("spurious_rxd", bus.rxd, 0);
        wait_for(0, n);
        chk("sb_setup", n, CS_SETUP - 1);
        chk("sb_take", bus.tx_take0, 1);
        chk("sb_tx", bus.spi_data_tx, 8'hA5);
        xfer(2);
        chk("sb_rxd", bus.rxd, 8'hA5);
        chk("sb_vld", bus.rx_vld0, 1);
        wait_for(1, n);
        chk("sb_done_lat", n, CS_HOLD);
        chk("sb_grant_in_done", bus.grant0, 1);
        bus.req0 = 0;
        step();
        chk("sb_grant_drop", bus.grant0, 0);
        chk("sb_no_grant1", n_g1, 0);

        // three-byte frame on requester 1
        bus.req1 = 1; bus.len1 = 2;
        wait_for(2, n);
        chk("tb_grant", {bus.grant1, bus.grant0}, 2);
        r0 = n_req;
        frame(3, 1'b1, 8'h01);
        chk("tb_req_count", n_req - r0, 3);
        chk("tb_cs_cont", n_cs_bad, 0);
        bus.req1 = 0;
        step();

        // tie after reset, then alternation with both held
        rst = 1;
        step();
        rst = 0;
        step();
        rx_xor = 8'h5A;
        bus.len0 = 0; bus.len1 = 0; bus.req0 = 1; bus.req1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_for(2, n);
            chk("tie_winner", {bus.grant1, bus.grant0}, (k % 2 == 0) ? 1 : 2);
            frame(1, 1'(k % 2), 8'h30 + 8'(k));
            if (k == 3) begin
                bus.req0 = 0;
                bus.req1 = 0;
            end
            step();
        end

        // mode and divider latched at grant
        bus.req0 = 1; bus.len0 = 1; bus.mode0 = 2'b11; bus.div0 = 16'd3;
        wait_for(2, n);
        chk("ml_mode_grant", {bus.spi_cpol, bus.spi_cpha}, 2'b11);
        chk("ml_div_grant", bus.spi_clk_div, 3);
        bus.mode0 = 2'b00; bus.div0 = 16'd9;
        frame(2, 1'b0, 8'h40);
        chk("ml_mode_done", {bus.spi_cpol, bus.spi_cpha}, 2'b11);
        chk("ml_div_done", bus.spi_clk_div, 3);
        bus.req0 = 0;
        step();
        chk("ml_mode_recover", {bus.spi_cpol, bus.spi_cpha}, 2'b11);
        chk("ml_div_recover", bus.spi_clk_div, 3);

        // maximum length frame, then recovery gap before requester 1
        bus.req0 = 1; bus.len0 = 15;
        wait_for(2, n);
        v0 = n_vld0;
        d0 = n_done0;
        frame(16, 1'b0, 8'h80);
        bus.req0 = 0; bus.req1 = 1; bus.len1 = 0;
        n = 0;
        while (!bus.grant1 && n < 100) begin
            step();
            n++;
        end
        chk("max_gap_ok", (n >= CS_GAP) && (n < 100), 1);
        chk("max_vld_count", n_vld0 - v0, 16);
        chk("max_done_count", n_done0 - d0, 1);
        frame(1, 1'b1, 8'h90);
        bus.req1 = 0;
        step();

        // reset during the second byte of a four-byte frame
        bus.req0 = 1; bus.len0 = 3;
        wait_for(2, n);
        d0 = n_done0;
        bus.txd0 = 8'h50;
        wait_for(0, n);
        xfer(1);
        bus.txd0 = 8'h51;
        wait_for(0, n);
        step();
        rst = 1;
        bus.req0 = 0;
        step();
        chk("mr_cs", bus.spi_cs_ctrl, 1);
        chk("mr_rxd", bus.rxd, 0);
        chk("mr_mode_div", {bus.spi_cpol, bus.spi_cpha, bus.spi_clk_div}, 0);
        chk("mr_outs", {bus.grant0, bus.grant1, bus.tx_take0, bus.tx_take1, bus.rx_vld0,
                        bus.rx_vld1, bus.done0, bus.done1, bus.spi_wr_req}, 0);
        rst = 0;
        repeat (10) step();
        chk("mr_no_done", n_done0 - d0, 0);
        bus.req0 = 1; bus.len0 = 0;
        wait_for(2, n);
        chk("mr_regrant", {bus.grant1, bus.grant0}, 1);
        frame(1, 1'b0, 8'h60);
        bus.req0 = 0;
        step();
        chk("mr_done_after", n_done0 - d0, 1);
        chk("cs_never_high_in_frame", n_cs_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
